// File: rtl/prof_stats.sv
// prof_stats: per-region invocation statistics built on the profiler's P_Count.
//
// Brackets each invocation of a code region with its entry/exit trace PCs.
// For each invocation it computes delta = P_Count(end) - P_Count(start), modulo 2^32,
// and accumulates call count, last, min, max and a 48-bit total.
//
// Ports:
//   clk                  system clock
//   reset                asynchronous, active-high reset
//   P_Trace_PC[31:0]     trace PC. Processor bus bit 0 (MSB) lands on bit 31 here,
//                        so the value compares numerically against ENTRY_ADDR/EXIT_ADDR.
//   P_Trace_Valid_Instr  trace PC valid / instruction completed this cycle
//   P_Count[31:0]        running region instruction count from the profiler
//   clear                synchronous clear of all statistics (highest priority)
//   rd_en, rd_addr[2:0]  single-cycle read request and register select
//   rd_data[31:0]        read data, valid with rd_valid one cycle after rd_en
//   rd_valid             one-cycle read-data-valid pulse
//   busy                 high while an invocation is open or being settled
module prof_stats #(
  parameter logic [31:0] ENTRY_ADDR = 32'h000001c8,
  parameter logic [31:0] EXIT_ADDR  = 32'h000001ec,
  parameter int unsigned COUNT_LAT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] P_Trace_PC,
  input  logic        P_Trace_Valid_Instr,
  input  logic [31:0] P_Count,
  input  logic        clear,
  input  logic        rd_en,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_SETTLE, S_UPDATE} state_t;

  localparam logic [3:0] LAT = 4'(COUNT_LAT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] n_calls_q, n_calls_d;
  logic [31:0] last_q, last_d;
  logic [31:0] min_q, min_d;
  logic [31:0] max_q, max_d;
  logic [47:0] total_q, total_d;
  logic [15:0] total_hi_shadow_q, total_hi_shadow_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  logic        entry_hit, exit_hit;
  logic [31:0] delta;
  logic [48:0] total_sum;

  assign entry_hit = P_Trace_Valid_Instr && (P_Trace_PC == ENTRY_ADDR);
  assign exit_hit  = P_Trace_Valid_Instr && (P_Trace_PC == EXIT_ADDR);
  assign delta     = P_Count - snap_q;  // modulo 2^32, wrap is legal
  assign total_sum = {1'b0, total_q} + {17'h0, delta};

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    snap_d            = snap_q;
    n_calls_d         = n_calls_q;
    last_d            = last_q;
    min_d             = min_q;
    max_d             = max_q;
    total_d           = total_q;
    total_hi_shadow_d = total_hi_shadow_q;
    err_d             = err_q;
    rd_valid_d        = rd_en;
    rd_data_d         = rd_data_q;

    case (state_q)
      S_IDLE: begin
        if (entry_hit) begin
          snap_d  = P_Count;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (entry_hit) err_d = 1'b1;  // recursion is not tracked
        if (exit_hit) begin
          cnt_d   = LAT;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Waits for the exit instruction to reach P_Count. UPDATE samples
        // P_Count COUNT_LAT+1 cycles after the exit, one cycle of margin.
        if (entry_hit) err_d = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (entry_hit) err_d = 1'b1;  // blind cycle: entry is not captured
        last_d    = delta;
        min_d     = (delta < min_q) ? delta : min_q;
        max_d     = (delta > max_q) ? delta : max_q;
        total_d   = total_sum[48] ? 48'hFFFF_FFFF_FFFF : total_sum[47:0];
        n_calls_d = (n_calls_q == 32'hFFFF_FFFF) ? n_calls_q : n_calls_q + 32'd1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reads see the registered (pre-update, pre-clear) statistics.
    if (rd_en) begin
      case (rd_addr)
        3'd0: rd_data_d = n_calls_q;
        3'd1: rd_data_d = last_q;
        3'd2: rd_data_d = min_q;
        3'd3: rd_data_d = max_q;
        3'd4: begin
          rd_data_d         = total_q[31:0];
          total_hi_shadow_d = total_q[47:32];  // coherent 48-bit read pair
        end
        3'd5: rd_data_d = {16'h0, total_hi_shadow_q};
        3'd6: rd_data_d = {29'h0, err_q, busy_q, (n_calls_q != 32'h0)};
        default: rd_data_d = 32'h0;
      endcase
    end

    // clear overrides everything except the read response already formed.
    if (clear) begin
      state_d           = S_IDLE;
      cnt_d             = 4'd0;
      snap_d            = 32'h0;
      n_calls_d         = 32'h0;
      last_d            = 32'h0;
      min_d             = 32'hFFFF_FFFF;
      max_d             = 32'h0;
      total_d           = 48'h0;
      total_hi_shadow_d = 16'h0;
      err_d             = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      cnt_q             <= 4'd0;
      snap_q            <= 32'h0;
      n_calls_q         <= 32'h0;
      last_q            <= 32'h0;
      min_q             <= 32'hFFFF_FFFF;
      max_q             <= 32'h0;
      total_q           <= 48'h0;
      total_hi_shadow_q <= 16'h0;
      err_q             <= 1'b0;
      busy_q            <= 1'b0;
      rd_data_q         <= 32'h0;
      rd_valid_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      snap_q            <= snap_d;
      n_calls_q         <= n_calls_d;
      last_q            <= last_d;
      min_q             <= min_d;
      max_q             <= max_d;
      total_q           <= total_d;
      total_hi_shadow_q <= total_hi_shadow_d;
      err_q             <= err_d;
      busy_q            <= busy_d;
      rd_data_q         <= rd_data_d;
      rd_valid_q        <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_prof_stats.sv
module tb_prof_stats;

  localparam logic [31:0] ENTRY = 32'h000001c8;
  localparam logic [31:0] EXIT  = 32'h000001ec;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] P_Trace_PC;
  logic        P_Trace_Valid_Instr;
  logic [31:0] P_Count;
  logic        clear;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;

  int tests = 0;
  int fails = 0;

  // Reference model: the statistics as plain numbers.
  logic [31:0]     m_calls, m_last, m_min, m_max;
  longint unsigned m_total;
  logic [15:0]     m_shadow;
  bit              m_err;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  prof_stats #(.ENTRY_ADDR(ENTRY), .EXIT_ADDR(EXIT), .COUNT_LAT(2)) dut (
    .clk(clk), .reset(reset), .P_Trace_PC(P_Trace_PC),
    .P_Trace_Valid_Instr(P_Trace_Valid_Instr), .P_Count(P_Count),
    .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_calls = 0; m_last = 0; m_min = 32'hFFFF_FFFF; m_max = 0;
    m_total = 0; m_shadow = 0; m_err = 0;
  endtask

  task automatic model_call(input logic [31:0] d);
    m_last = d;
    if (d < m_min) m_min = d;
    if (d > m_max) m_max = d;
    m_total = m_total + longint'(d);
    if (m_total > 64'h0000_FFFF_FFFF_FFFF) m_total = 64'h0000_FFFF_FFFF_FFFF;
    if (m_calls != 32'hFFFF_FFFF) m_calls = m_calls + 1;
  endtask

  function automatic logic [31:0] model_reg(input logic [2:0] a);
    logic [63:0] t;
    t = m_total;
    case (a)
      3'd0: return m_calls;
      3'd1: return m_last;
      3'd2: return m_min;
      3'd3: return m_max;
      3'd4: return t[31:0];
      3'd5: return {16'h0, m_shadow};
      3'd6: return {29'h0, m_err, 1'b0, (m_calls != 0)};
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got rd_valid=1 data=%h, expected no response", rd_data);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] read addr=%0d data=%h", e.addr, rd_data);
        check($sformatf("rd_addr%0d", e.addr), rd_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one read this cycle; leaves rd_en high so reads can run back-to-back.
  task automatic do_read(input logic [2:0] a);
    exp_t e;
    logic [63:0] t;
    rd_en = 1'b1;
    rd_addr = a;
    e.addr = a;
    e.data = model_reg(a);
    exp_q.push_back(e);
    if (a == 3'd4) begin
      t = m_total;
      m_shadow = t[47:32];
    end
    tick();
    check("rd_latency", 32'(rd_valid), 32'd1);
  endtask

  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) do_read(3'(a));
    rd_en = 1'b0;
    tick();
  endtask

  task automatic do_call(input logic [31:0] snap, input logic [31:0] d, input bit reenter);
    int gap;
    int n;
    P_Count = snap;
    P_Trace_PC = ENTRY;
    P_Trace_Valid_Instr = 1'b1;
    tick();
    P_Trace_Valid_Instr = 1'b0;
    check("busy_after_entry", 32'(busy), 32'd1);
    gap = $urandom_range(0, 3);
    for (int g = 0; g < gap; g++) begin
      P_Trace_PC = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
      P_Trace_Valid_Instr = 1'($urandom_range(0, 1));
      P_Count = snap + 32'(g);
      tick();
    end
    if (reenter) begin
      P_Trace_PC = ENTRY;
      P_Trace_Valid_Instr = 1'b1;
      P_Count = snap + 32'd7;
      tick();
      m_err = 1'b1;
    end
    P_Trace_PC = EXIT;
    P_Trace_Valid_Instr = 1'b1;
    P_Count = snap + d - 32'd1;
    tick();
    P_Trace_Valid_Instr = 1'b0;
    P_Count = snap + d;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("busy_drop", 32'(busy), 32'd0);
    model_call(d);
    $display("[TB] call snap=%h delta=%h", snap, d);
  endtask

  initial begin
    reset = 1'b1;
    P_Trace_PC = 32'h0;
    P_Trace_Valid_Instr = 1'b0;
    P_Count = 32'h0;
    clear = 1'b0;
    rd_en = 1'b0;
    rd_addr = 3'd0;
    model_reset();
    repeat (3) tick();
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    read_range(0, 7);

    // Basic call and then deltas 4 and 25.
    do_call(32'd100, 32'd10, 1'b0);
    read_range(0, 6);
    do_call($urandom, 32'd4, 1'b0);
    do_call($urandom, 32'd25, 1'b0);
    read_range(0, 5);

    // Wrap of P_Count across 2^32.
    do_call(32'hFFFF_FFFE, 32'd5, 1'b0);
    read_range(1, 3);

    // Re-entry while open, then a spurious exit while idle.
    do_call($urandom, 32'd17, 1'b1);
    P_Trace_PC = EXIT;
    P_Trace_Valid_Instr = 1'b1;
    P_Count = $urandom;
    tick();
    P_Trace_Valid_Instr = 1'b0;
    check("busy_spurious_exit", 32'(busy), 32'd0);
    read_range(0, 1);
    read_range(6, 6);

    // Randomized calls and reads.
    for (int i = 0; i < 20; i++) begin
      do_call($urandom, 32'($urandom_range(0, 5000)), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        for (int r = 0; r < 3; r++) do_read(3'($urandom_range(0, 7)));
        rd_en = 1'b0;
        tick();
      end
    end

    // Total crossing 2^32; the address-5 read must show the shadow latched at address 4.
    do_call(32'h0, 32'hF000_0000, 1'b0);
    do_call(32'h0, 32'hF000_0000, 1'b0);
    read_range(4, 4);
    do_call(32'h0, 32'hF000_0000, 1'b0);
    read_range(5, 5);
    read_range(4, 5);

    // Clear while ACTIVE, with a read in the same cycle returning pre-clear data.
    P_Count = 32'd50;
    P_Trace_PC = ENTRY;
    P_Trace_Valid_Instr = 1'b1;
    tick();
    P_Trace_Valid_Instr = 1'b0;
    clear = 1'b1;
    do_read(3'd0);
    clear = 1'b0;
    rd_en = 1'b0;
    model_reset();
    check("busy_after_clear", 32'(busy), 32'd0);
    P_Trace_PC = EXIT;
    P_Trace_Valid_Instr = 1'b1;
    P_Count = 32'd90;
    tick();
    P_Trace_Valid_Instr = 1'b0;
    check("busy_exit_after_clear", 32'(busy), 32'd0);
    repeat (4) tick();
    read_range(0, 6);
    do_call(32'd200, 32'd33, 1'b0);
    read_range(0, 3);

    // Asynchronous reset in SETTLE with a read request pending.
    P_Count = 32'd1000;
    P_Trace_PC = ENTRY;
    P_Trace_Valid_Instr = 1'b1;
    tick();
    P_Trace_PC = EXIT;
    tick();
    P_Trace_Valid_Instr = 1'b0;
    check("busy_in_settle", 32'(busy), 32'd1);
    rd_en = 1'b1;
    rd_addr = 3'd0;
    #2;
    reset = 1'b1;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_rd_valid", 32'(rd_valid), 32'd0);
    check("async_rd_data", rd_data, 32'h0);
    rd_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    read_range(0, 6);
    repeat (3) tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prof_stats.md
Name: prof_stats

Overview:
- Downstream consumer of the address-range profiler's 32-bit P_Count.
- Brackets each invocation of a code region using trace entry/exit PCs and computes the instruction-count delta per invocation.
- Accumulates per-region statistics: call count, last, min, max and total.
- Exposes the statistics through a simple registered read port for software or a debug bus.

Parameters:
- ENTRY_ADDR, 32'h000001c8, PC of the region's first instruction (invocation start).
- EXIT_ADDR, 32'h000001ec, PC of the region's last instruction (invocation end). Must differ from ENTRY_ADDR.
- COUNT_LAT, 2, cycles from a valid trace instruction to its effect on P_Count (registered enable plus counter). Range 1-15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- P_Trace_PC  in  32  processor trace PC, bit 0 = MSB (processor bus order).
- P_Trace_Valid_Instr  in  1  trace PC valid / instruction completed this cycle.
- P_Count  in  32  running region instruction count from the profiler counter.
- clear  in  1  synchronous clear of all statistics.
- rd_en  in  1  read request, single-cycle.
- rd_addr  in  3  register select.
- rd_data  out  32  read data.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- busy  out  1  high while an invocation is open or being settled.

Behaviour:
- Reset (async), all outputs and state:
  - state=IDLE; snap=0, n_calls=0, last=0, min=32'hFFFFFFFF, max=0, total(48b)=0, total_hi_shadow=0, err=0.
  - rd_data=0, rd_valid=0, busy=0.
- Event definitions:
  - entry_hit = P_Trace_Valid_Instr & (P_Trace_PC==ENTRY_ADDR).
  - exit_hit = P_Trace_Valid_Instr & (P_Trace_PC==EXIT_ADDR).
- State machine:
  - IDLE: on entry_hit, snap<=P_Count (sampled the same cycle), go to ACTIVE. exit_hit is ignored.
  - ACTIVE: on exit_hit, load settle counter with COUNT_LAT and go to SETTLE. entry_hit (re-entry/recursion) is ignored and sets err sticky.
  - SETTLE: decrement the counter each cycle; at zero go to UPDATE. Trace events are ignored except entry_hit, which sets err.
  - UPDATE (one cycle):
    - delta = P_Count - snap, modulo 2^32 (wrap is legal).
    - last<=delta; min<=min(min,delta); max<=max(max,delta).
    - total<=total+delta, saturating at 48'hFFFF_FFFF_FFFF.
    - n_calls<=n_calls+1, saturating at 32'hFFFFFFFF.
    - Go to IDLE.
    - entry_hit in this same cycle is NOT captured (documented blind cycle) and sets err.
- busy = (state != IDLE), registered with the state.
- clear: synchronous and highest priority. All statistics return to their reset values, err=0, state=IDLE. An open invocation is dropped. clear has no effect on an in-flight read response.
- Read port:
  - rd_en in cycle N gives rd_valid=1 and rd_data in cycle N+1. Back-to-back reads are allowed every cycle.
  - Address map:
    - 0: n_calls
    - 1: last
    - 2: min (reads 32'hFFFFFFFF until the first call completes)
    - 3: max
    - 4: total[31:0]; this read also latches total[47:32] into total_hi_shadow
    - 5: {16'h0, total_hi_shadow}
    - 6: {29'h0, err, busy, (n_calls!=0)}
    - 7: 32'h0
  - A read and an UPDATE in the same cycle return the pre-update value.
  - A read and a clear in the same cycle return the pre-clear value.
- Reset asserted mid-invocation or mid-read: immediate return to reset values; no rd_valid is produced for a read lost to reset.

Test Plan:
- Basic call:
  - Stimulus: P_Count=100 at the entry_hit cycle; exit_hit later; P_Count=110 COUNT_LAT cycles after exit.
  - Required: n_calls=1, last=min=max=10, total=10, busy low one cycle after UPDATE.
- Three calls with deltas 10, 4, 25:
  - Required: min=4, max=25, total=39, last=25. Reads of addresses 0-3 return 3, 25, 4, 25, each with rd_valid exactly one cycle after rd_en.
- Wrap:
  - Stimulus: snap=32'hFFFFFFFE, P_Count at sample=32'h00000003.
  - Required: delta=5.
- Re-entry and spurious exit:
  - Stimulus: entry_hit while ACTIVE; exit_hit while IDLE.
  - Required: err=1 (address 6 bit 2 set), no extra n_calls increment, snap unchanged.
- Total split:
  - Stimulus: preload via many calls so total crosses 2^32; read address 4, then another call completes, then read address 5.
  - Required: address 5 returns the upper bits captured at the address-4 read, not the updated value.
- Clear / reset:
  - clear while ACTIVE: state=IDLE, min=32'hFFFFFFFF, n_calls=0, and the following exit_hit is ignored.
  - Async reset mid-SETTLE: all outputs 0 and busy=0 with no clock edge.
